// File: rtl/nfc_pingpong_page_buffer.sv
// ---------------------------------------------------------------------------
// nfc_pingpong_page_buffer
//
// Two-bank (ping-pong) page buffer between the host interface and the NAND
// flash controller datapath. One bank is filled while the other is drained,
// so pages can stream back to back.
//
//   dir = 0 (program): host writes pages, controller reads them.
//   dir = 1 (read)   : controller writes pages, host reads them.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   dir                 transfer direction, taken only while the buffer is idle
//   flush               clears banks, counters and pointers; keeps mode/errors
//   clr_err             clears the sticky error flags
//   buf_sel/we/re/in    host-side strobes and write data
//   buf_out(_vld)       host read data (registered) and its one-cycle valid
//   cntrl_sel/we/re/in  controller-side strobes and write data
//   cntrl_out(_vld)     controller read data (registered) and its valid
//   host_buf_status     host may act (write bank not full / read bank full)
//   buf_cntrl_status    controller may act (read bank full / write bank not full)
//   pages_full          number of full banks, 0..2
//   ovf_err             sticky: write to a full bank
//   udf_err             sticky: read with no full bank
//   mode_err            sticky: dir changed while not idle
// ---------------------------------------------------------------------------
module nfc_pingpong_page_buffer #(
   parameter int DataWidth = 16,
   parameter int PageWords = 2048,
   parameter int CntWidth  = $clog2(PageWords)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dir,
   input  logic                 flush,
   input  logic                 clr_err,
   input  logic                 buf_sel,
   input  logic                 buf_we,
   input  logic                 buf_re,
   input  logic [DataWidth-1:0] buf_in,
   output logic [DataWidth-1:0] buf_out,
   output logic                 buf_out_vld,
   input  logic                 cntrl_sel,
   input  logic                 cntrl_we,
   input  logic                 cntrl_re,
   input  logic [DataWidth-1:0] cntrl_in,
   output logic [DataWidth-1:0] cntrl_out,
   output logic                 cntrl_out_vld,
   output logic                 host_buf_status,
   output logic                 buf_cntrl_status,
   output logic [1:0]           pages_full,
   output logic                 ovf_err,
   output logic                 udf_err,
   output logic                 mode_err
);

   typedef enum logic {
      DIR_PROGRAM = 1'b0,   // host -> controller
      DIR_READ    = 1'b1    // controller -> host
   } dir_e;

   localparam logic [CntWidth-1:0] LastWord = CntWidth'(PageWords - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DataWidth-1:0] mem [2][PageWords];
   dir_e                 dir_q;
   logic                 wr_bank, rd_bank;
   logic [CntWidth-1:0]  wr_cnt, rd_cnt;
   logic [1:0]           bank_full;

   // ------------------------------------------------------------------------
   // Event decode (all decisions use registered, pre-update state)
   // ------------------------------------------------------------------------
   logic                 wr_ev, rd_ev;
   logic                 wr_ok, rd_ok;
   logic                 ovf_set, udf_set, mode_set;
   logic                 idle;
   logic [DataWidth-1:0] wr_data;
   logic [1:0]           bank_full_nxt;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      wr_ev         = 1'b0;
      rd_ev         = 1'b0;
      wr_data       = buf_in;
      bank_full_nxt = bank_full;

      // Strobes on the side that is not the writer/reader are simply ignored.
      if (dir_q == DIR_PROGRAM) begin
         wr_ev   = buf_sel & buf_we;
         rd_ev   = cntrl_sel & cntrl_re;
         wr_data = buf_in;
      end else begin
         wr_ev   = cntrl_sel & cntrl_we;
         rd_ev   = buf_sel & buf_re;
         wr_data = cntrl_in;
      end

      idle = (bank_full == 2'b00) && (wr_cnt == '0) && (rd_cnt == '0);

      // flush discards same-cycle strobes, so they neither act nor flag errors.
      wr_ok    = wr_ev & ~bank_full[wr_bank] & ~flush;
      ovf_set  = wr_ev &  bank_full[wr_bank] & ~flush;
      rd_ok    = rd_ev &  bank_full[rd_bank] & ~flush;
      udf_set  = rd_ev & ~bank_full[rd_bank] & ~flush;
      mode_set = ~flush & ~idle & (dir_e'(dir) != dir_q);

      // A write can only target a non-full bank and a read only a full one,
      // so the two updates never touch the same bank in one cycle.
      if (wr_ok && wr_cnt == LastWord) bank_full_nxt[wr_bank] = 1'b1;
      if (rd_ok && rd_cnt == LastWord) bank_full_nxt[rd_bank] = 1'b0;
   end

   // ------------------------------------------------------------------------
   // Page storage
   // ------------------------------------------------------------------------
   // NOTE: the data array is deliberately left out of reset; only the
   // pointers and flags that say which words are meaningful are cleared.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_bank][wr_cnt] <= wr_data;
   end

   // ------------------------------------------------------------------------
   // Control state and registered outputs
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q         <= DIR_PROGRAM;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         bank_full     <= 2'b00;
         buf_out       <= '0;
         buf_out_vld   <= 1'b0;
         cntrl_out     <= '0;
         cntrl_out_vld <= 1'b0;
         ovf_err       <= 1'b0;
         udf_err       <= 1'b0;
         mode_err      <= 1'b0;
      end else if (flush) begin
         // Pointers restart; direction, last output data and errors survive.
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         wr_cnt        <= '0;
         rd_cnt        <= '0;
         bank_full     <= 2'b00;
         buf_out_vld   <= 1'b0;
         cntrl_out_vld <= 1'b0;
      end else begin
         if (idle) dir_q <= dir_e'(dir);

         bank_full <= bank_full_nxt;

         if (wr_ok) begin
            if (wr_cnt == LastWord) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end

         if (rd_ok) begin
            if (rd_cnt == LastWord) begin
               rd_cnt  <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
         end

         // Output data holds between reads; valid is a single-cycle pulse.
         buf_out_vld   <= rd_ok & (dir_q == DIR_READ);
         cntrl_out_vld <= rd_ok & (dir_q == DIR_PROGRAM);
         if (rd_ok && dir_q == DIR_READ)    buf_out   <= mem[rd_bank][rd_cnt];
         if (rd_ok && dir_q == DIR_PROGRAM) cntrl_out <= mem[rd_bank][rd_cnt];

         // A new error in the same cycle as clr_err wins.
         ovf_err  <= ovf_set  | (ovf_err  & ~clr_err);
         udf_err  <= udf_set  | (udf_err  & ~clr_err);
         mode_err <= mode_set | (mode_err & ~clr_err);
      end
   end

   // ------------------------------------------------------------------------
   // Status, derived from registered state only
   // ------------------------------------------------------------------------
   always_comb begin
      pages_full = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};
      if (dir_q == DIR_PROGRAM) begin
         host_buf_status  = ~bank_full[wr_bank];
         buf_cntrl_status =  bank_full[rd_bank];
      end else begin
         host_buf_status  =  bank_full[rd_bank];
         buf_cntrl_status = ~bank_full[wr_bank];
      end
   end

endmodule

// File: tb/tb_nfc_pingpong_page_buffer.sv
// ---------------------------------------------------------------------------
// tb_nfc_pingpong_page_buffer
//
// Self-checking bench for nfc_pingpong_page_buffer with an 8-word page.
// Every successful read pushes the expected word into a per-side queue; a
// monitor pops and compares on each valid pulse. Flags and status are
// compared inline by each scenario task.
// ---------------------------------------------------------------------------
module tb_nfc_pingpong_page_buffer;

   localparam int DW = 16;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst, dir, flush, clr_err;
   logic          buf_sel, buf_we, buf_re;
   logic [DW-1:0] buf_in, buf_out;
   logic          buf_out_vld;
   logic          cntrl_sel, cntrl_we, cntrl_re;
   logic [DW-1:0] cntrl_in, cntrl_out;
   logic          cntrl_out_vld;
   logic          host_buf_status, buf_cntrl_status;
   logic [1:0]    pages_full;
   logic          ovf_err, udf_err, mode_err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DW-1:0] exp_c[$];
   logic [DW-1:0] exp_h[$];
   logic [DW-1:0] mon_c, mon_h;

   nfc_pingpong_page_buffer #(
      .DataWidth (DW),
      .PageWords (PW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .dir              (dir),
      .flush            (flush),
      .clr_err          (clr_err),
      .buf_sel          (buf_sel),
      .buf_we           (buf_we),
      .buf_re           (buf_re),
      .buf_in           (buf_in),
      .buf_out          (buf_out),
      .buf_out_vld      (buf_out_vld),
      .cntrl_sel        (cntrl_sel),
      .cntrl_we         (cntrl_we),
      .cntrl_re         (cntrl_re),
      .cntrl_in         (cntrl_in),
      .cntrl_out        (cntrl_out),
      .cntrl_out_vld    (cntrl_out_vld),
      .host_buf_status  (host_buf_status),
      .buf_cntrl_status (buf_cntrl_status),
      .pages_full       (pages_full),
      .ovf_err          (ovf_err),
      .udf_err          (udf_err),
      .mode_err         (mode_err)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (cntrl_out_vld === 1'b1) begin
         tests_run++;
         if (exp_c.size() == 0) begin
            tests_failed++;
            $display("FAIL cntrl_sb: unexpected word got %h, want none", cntrl_out);
         end else begin
            mon_c = exp_c.pop_front();
            if (cntrl_out !== mon_c) begin
               tests_failed++;
               $display("FAIL cntrl_sb: got %h want %h", cntrl_out, mon_c);
            end
         end
      end
      if (buf_out_vld === 1'b1) begin
         tests_run++;
         if (exp_h.size() == 0) begin
            tests_failed++;
            $display("FAIL host_sb: unexpected word got %h, want none", buf_out);
         end else begin
            mon_h = exp_h.pop_front();
            if (buf_out !== mon_h) begin
               tests_failed++;
               $display("FAIL host_sb: got %h want %h", buf_out, mon_h);
            end
         end
      end
   end

   // One clock of stimulus; strobes return low afterwards. Outputs are
   // stable 1 time unit after the edge.
   task automatic drive(input logic hw, input logic hr, input logic cw, input logic cr,
                        input logic [DW-1:0] hin = '0, input logic [DW-1:0] cin = '0);
      buf_sel   = hw | hr;
      buf_we    = hw;
      buf_re    = hr;
      buf_in    = hin;
      cntrl_sel = cw | cr;
      cntrl_we  = cw;
      cntrl_re  = cr;
      cntrl_in  = cin;
      @(posedge clk);
      #1;
      buf_sel   = 1'b0;
      buf_we    = 1'b0;
      buf_re    = 1'b0;
      cntrl_sel = 1'b0;
      cntrl_we  = 1'b0;
      cntrl_re  = 1'b0;
   endtask

   task automatic idle_cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_errors();
      clr_err = 1'b1;
      idle_cycle();
      clr_err = 1'b0;
   endtask

   // Controller drains n words of a page in program mode; each word expected.
   task automatic cntrl_drain(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         exp_c.push_back(base + DW'(i));
         drive(1'b0, 1'b0, 1'b0, 1'b1);
         tests_run++;
         if (cntrl_out_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL cntrl_vld_latency: word %0d got %b want 1", i, cntrl_out_vld);
         end
      end
   endtask

   task automatic host_fill(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, base + DW'(i));
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      idle_cycle();
      idle_cycle();
      tests_run++;
      if ({buf_out, cntrl_out} !== '0 || {buf_out_vld, cntrl_out_vld} !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_data: got buf_out=%h cntrl_out=%h vld=%b%b want 0",
                  buf_out, cntrl_out, buf_out_vld, cntrl_out_vld);
      end
      tests_run++;
      if ({pages_full, ovf_err, udf_err, mode_err, buf_cntrl_status} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got pf=%0d ovf=%b udf=%b mode=%b bcs=%b want 0",
                  pages_full, ovf_err, udf_err, mode_err, buf_cntrl_status);
      end
      rst = 1'b0;
      idle_cycle();
      // Program mode with an empty write bank: host may write.
      tests_run++;
      if (host_buf_status !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_host_status: got %b want 1", host_buf_status);
      end
   endtask

   task automatic test_program_page();
      host_fill(PW - 1, 16'h0001);
      tests_run++;
      if (pages_full !== 2'd0) begin
         tests_failed++;
         $display("FAIL prog_partial_pages: got %0d want 0", pages_full);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0008);
      tests_run++;
      if (pages_full !== 2'd1 || buf_cntrl_status !== 1'b1 || host_buf_status !== 1'b1) begin
         tests_failed++;
         $display("FAIL prog_full_status: got pf=%0d bcs=%b hbs=%b want 1 1 1",
                  pages_full, buf_cntrl_status, host_buf_status);
      end
      cntrl_drain(PW, 16'h0001);
      idle_cycle();
      tests_run++;
      if (pages_full !== 2'd0 || cntrl_out !== 16'h0008 || cntrl_out_vld !== 1'b0) begin
         tests_failed++;
         $display("FAIL prog_drained: got pf=%0d out=%h vld=%b want 0 0008 0",
                  pages_full, cntrl_out, cntrl_out_vld);
      end
   endtask

   task automatic test_overflow();
      host_fill(2 * PW, 16'h0100);
      tests_run++;
      if (pages_full !== 2'd2 || host_buf_status !== 1'b0 || ovf_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_both_full: got pf=%0d hbs=%b ovf=%b want 2 0 0",
                  pages_full, host_buf_status, ovf_err);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hDEAD);
      tests_run++;
      if (ovf_err !== 1'b1 || pages_full !== 2'd2) begin
         tests_failed++;
         $display("FAIL ovf_17th: got ovf=%b pf=%0d want 1 2", ovf_err, pages_full);
      end
      cntrl_drain(2 * PW, 16'h0100);
      tests_run++;
      if (pages_full !== 2'd0) begin
         tests_failed++;
         $display("FAIL ovf_drained: got pf=%0d want 0", pages_full);
      end
      clear_errors();
      tests_run++;
      if (ovf_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_clear: got %b want 0", ovf_err);
      end
   endtask

   task automatic test_streaming();
      host_fill(PW, 16'h1000);
      for (int i = 0; i < PW; i++) begin
         exp_c.push_back(16'h1000 + DW'(i));
         drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h2000 + DW'(i));
         tests_run++;
         if (ovf_err !== 1'b0 || udf_err !== 1'b0 || pages_full > 2'd2) begin
            tests_failed++;
            $display("FAIL stream_cycle%0d: got ovf=%b udf=%b pf=%0d want 0 0 <=2",
                     i, ovf_err, udf_err, pages_full);
         end
      end
      tests_run++;
      if (pages_full !== 2'd1) begin
         tests_failed++;
         $display("FAIL stream_pages: got %0d want 1", pages_full);
      end
      cntrl_drain(PW, 16'h2000);
   endtask

   // Both banks full; the cycle that frees one bank also carries a write,
   // which must be rejected because status is judged on pre-update state.
   task automatic test_back_to_back();
      host_fill(2 * PW, 16'h3000);
      cntrl_drain(PW - 1, 16'h3000);
      exp_c.push_back(16'h3000 + DW'(PW - 1));
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'hBAD0);
      tests_run++;
      if (ovf_err !== 1'b1 || pages_full !== 2'd1) begin
         tests_failed++;
         $display("FAIL b2b_free_write: got ovf=%b pf=%0d want 1 1", ovf_err, pages_full);
      end
      cntrl_drain(PW, 16'h3000 + DW'(PW));
      tests_run++;
      if (pages_full !== 2'd0) begin
         tests_failed++;
         $display("FAIL b2b_drained: got %0d want 0", pages_full);
      end
      clear_errors();
   endtask

   task automatic test_read_mode();
      dir = 1'b1;
      idle_cycle();
      for (int i = 0; i < PW; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 16'hA000 + DW'(i));
      tests_run++;
      if (host_buf_status !== 1'b1 || buf_cntrl_status !== 1'b1 || pages_full !== 2'd1) begin
         tests_failed++;
         $display("FAIL rd_full_status: got hbs=%b bcs=%b pf=%0d want 1 1 1",
                  host_buf_status, buf_cntrl_status, pages_full);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (cntrl_out_vld !== 1'b0 || udf_err !== 1'b0 || pages_full !== 2'd1) begin
         tests_failed++;
         $display("FAIL rd_wrong_side_re: got vld=%b udf=%b pf=%0d want 0 0 1",
                  cntrl_out_vld, udf_err, pages_full);
      end
      for (int i = 0; i < PW; i++) begin
         exp_h.push_back(16'hA000 + DW'(i));
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         tests_run++;
         if (buf_out_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL host_vld_latency: word %0d got %b want 1", i, buf_out_vld);
         end
      end
      dir = 1'b0;
      idle_cycle();
   endtask

   task automatic test_errors();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++;
      if (udf_err !== 1'b1 || cntrl_out_vld !== 1'b0) begin
         tests_failed++;
         $display("FAIL udf_set: got udf=%b vld=%b want 1 0", udf_err, cntrl_out_vld);
      end
      clear_errors();
      tests_run++;
      if (udf_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL udf_clear: got %b want 0", udf_err);
      end
      clr_err = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      clr_err = 1'b0;
      tests_run++;
      if (udf_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL udf_beats_clear: got %b want 1", udf_err);
      end
      clear_errors();

      host_fill(3, 16'h4000);
      dir = 1'b1;
      idle_cycle();
      tests_run++;
      if (mode_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL mode_set: got %b want 1", mode_err);
      end
      // Direction still program: host writes keep landing in the page.
      host_fill(PW - 3, 16'h4003);
      tests_run++;
      if (pages_full !== 2'd1 || buf_cntrl_status !== 1'b1) begin
         tests_failed++;
         $display("FAIL mode_dir_held: got pf=%0d bcs=%b want 1 1", pages_full, buf_cntrl_status);
      end
      dir = 1'b0;
      cntrl_drain(PW, 16'h4000);
      clear_errors();
      tests_run++;
      if (mode_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL mode_clear: got %b want 0", mode_err);
      end
   endtask

   task automatic test_flush_and_rst();
      host_fill(5, 16'h5000);
      flush = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF);
      flush = 1'b0;
      tests_run++;
      if (pages_full !== 2'd0 || host_buf_status !== 1'b1 || buf_cntrl_status !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_state: got pf=%0d hbs=%b bcs=%b want 0 1 0",
                  pages_full, host_buf_status, buf_cntrl_status);
      end
      host_fill(PW - 1, 16'h6000);
      tests_run++;
      if (pages_full !== 2'd0) begin
         tests_failed++;
         $display("FAIL flush_wrcnt: got pf=%0d after %0d words want 0", pages_full, PW - 1);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h6000 + DW'(PW - 1));
      cntrl_drain(PW, 16'h6000);

      host_fill(5, 16'h7000);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      idle_cycle();
      tests_run++;
      if ({buf_out, cntrl_out, buf_out_vld, cntrl_out_vld, pages_full,
           ovf_err, udf_err, mode_err, buf_cntrl_status} !== '0) begin
         tests_failed++;
         $display("FAIL rst_outputs: got bo=%h co=%h pf=%0d udf=%b bcs=%b want 0",
                  buf_out, cntrl_out, pages_full, udf_err, buf_cntrl_status);
      end
      rst = 1'b0;
      host_fill(PW, 16'h8000);
      cntrl_drain(PW, 16'h8000);
   endtask

   // ------------------------------------------------------------------------
   initial begin
      rst = 1'b1; dir = 1'b0; flush = 1'b0; clr_err = 1'b0;
      buf_sel = 1'b0; buf_we = 1'b0; buf_re = 1'b0; buf_in = '0;
      cntrl_sel = 1'b0; cntrl_we = 1'b0; cntrl_re = 1'b0; cntrl_in = '0;

      test_reset();
      test_program_page();
      test_overflow();
      test_streaming();
      test_back_to_back();
      test_read_mode();
      test_errors();
      test_flush_and_rst();

      idle_cycle();
      idle_cycle();
      tests_run++;
      if (exp_c.size() != 0 || exp_h.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_leftover: got cntrl=%0d host=%0d pending want 0 0",
                  exp_c.size(), exp_h.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/nfc_pingpong_page_buffer.md
Name: nfc_pingpong_page_buffer

Overview:
Two-bank (ping-pong) page buffer between the host interface and the NAND flash controller datapath. Width and page depth are parametrised, and transfer direction is selectable. In program mode (dir=0) the host fills pages and the controller drains them. In read mode (dir=1) the controller fills pages and the host drains them. While one bank is drained the other bank can be filled, giving back-to-back page streaming with page-granular status flags and sticky error reporting.

Parameters:
DataWidth, 16, word width of all data ports.
PageWords, 2048, words per page (per bank); power of two, >= 4.
CntWidth, $clog2(PageWords), width of the word counters.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
dir  input  1  0 = host->cntrl (program), 1 = cntrl->host (read); sampled only when idle.
flush  input  1  synchronous clear of banks, counters and pointers; mode and errors kept.
clr_err  input  1  clears sticky error flags.
buf_sel, buf_we, buf_re  input  1 each  host-side select / write / read strobes.
buf_in  input  DataWidth  host write data.
buf_out  output  DataWidth  host read data, registered.
buf_out_vld  output  1  buf_out valid pulse.
cntrl_sel, cntrl_we, cntrl_re  input  1 each  controller-side strobes.
cntrl_in  input  DataWidth  controller write data.
cntrl_out  output  DataWidth  controller read data, registered.
cntrl_out_vld  output  1  cntrl_out valid pulse.
host_buf_status  output  1  host side may act: dir=0 write bank not full; dir=1 read bank full.
buf_cntrl_status  output  1  controller side may act: dir=0 read bank full; dir=1 write bank not full.
pages_full  output  2  number of full banks (0..2).
ovf_err  output  1  sticky: write attempted to a full bank.
udf_err  output  1  sticky: read attempted with no full bank.
mode_err  output  1  sticky: dir changed while not idle.

Behaviour:
- Reset values: all outputs 0; dir_q=0, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, bank_full=2'b00. Memory contents are not reset.
- Writer side is host if dir_q=0, else controller. Reader side is the other side. Strobes on the wrong side (e.g. host we in dir_q=0 is legal; host re in dir_q=0 is not) are ignored, with no error.
- Write event: writer sel & we. If bank_full[wr_bank]=0, store word at mem[wr_bank][wr_cnt] and increment wr_cnt. Otherwise drop the word and set ovf_err.
- Write of word PageWords-1: next cycle bank_full[wr_bank]=1, wr_bank toggles, wr_cnt=0.
- Read event: reader sel & re. If bank_full[rd_bank]=1, the word mem[rd_bank][rd_cnt] appears on the reader's out port one cycle later with the matching _vld=1 for exactly that cycle, and rd_cnt increments. Otherwise set udf_err; out data holds and vld stays 0.
- Read of word PageWords-1: next cycle bank_full[rd_bank]=0, rd_bank toggles, rd_cnt=0.
- Out data registers hold their last value when no read occurs.
- Simultaneous write and read in one cycle: both proceed on their own banks. Status and full flags are evaluated on pre-update (registered) state, so a write to a bank freed in that same cycle is rejected with ovf_err (only possible when both banks are full).
- Idle = bank_full==0 && wr_cnt==0 && rd_cnt==0. dir is copied into dir_q only when idle. If dir != dir_q while not idle, dir_q is held and mode_err is set.
- Status outputs and pages_full are combinational from registered state, i.e. valid the cycle after the event that changed them.
- flush: same effect as reset on pointers, counters, bank_full and the vld outputs; dir_q, out data and error flags are kept. flush has priority over same-cycle strobes, which are discarded.
- clr_err clears all three error flags. If an error occurs in the same cycle as clr_err, the error wins (flag set).
- rst mid-page: the partial page is discarded and all state returns to reset values next cycle.
- Counters are CntWidth bits and wrap only through the page-complete rule; no other wrap-around exists.

Test Plan:
1. PageWords=8, dir=0; host writes 8 words 0x0001..0x0008 -> pages_full=1, buf_cntrl_status=1, host_buf_status=1; controller reads 8 -> cntrl_out 0x0001..0x0008 each 1 cycle after re, vld pulses, pages_full=0.
2. PageWords=8, dir=0; host writes 16 words then a 17th -> pages_full=2, host_buf_status=0, ovf_err=1, 17th word absent; controller drains 16 words in order.
3. Streaming: host writes bank1 while controller reads bank0 in the same cycles -> no errors, data order preserved, pages_full never exceeds 2.
4. dir=1, controller writes 8 words 0xA000..0xA007, host reads -> buf_out matches; a controller re in this mode produces no read and no error.
5. Controller re with pages_full=0 -> udf_err=1, cntrl_out_vld=0; then clr_err -> udf_err=0. Toggle dir after 3 written words -> mode_err=1 and direction unchanged.
6. Write 5 words, then flush -> pages_full=0, wr_cnt=0; next full page reads back correctly. Repeat with rst -> all outputs 0.
